// File: rtl/calc1_pkg.sv
// Shared widths, command/response encodings and channel FSM states for calc1.
package calc1_pkg;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CMD_W   = 4;
  localparam int unsigned RESP_W  = 2;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [CMD_W-1:0] CMD_NOP = 4'd0;
  localparam logic [CMD_W-1:0] CMD_ADD = 4'd1;
  localparam logic [CMD_W-1:0] CMD_SUB = 4'd2;
  localparam logic [CMD_W-1:0] CMD_SHL = 4'd5;
  localparam logic [CMD_W-1:0] CMD_SHR = 4'd6;

  localparam logic [RESP_W-1:0] RESP_NONE    = 2'd0;
  localparam logic [RESP_W-1:0] RESP_OK      = 2'd1;
  localparam logic [RESP_W-1:0] RESP_ERR     = 2'd2;
  localparam logic [RESP_W-1:0] RESP_INVALID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_EXEC = 2'd2
  } state_e;

endpackage

// File: rtl/calc1_if.sv
// Four request/response port pairs of calc1; master drives requests, slave returns responses.
interface calc1_if;
  import calc1_pkg::*;

  logic [CMD_W-1:0]  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in;
  logic [DATA_W-1:0] req1_data_in, req2_data_in, req3_data_in, req4_data_in;
  logic [RESP_W-1:0] out_resp1, out_resp2, out_resp3, out_resp4;
  logic [DATA_W-1:0] out_data1, out_data2, out_data3, out_data4;

  modport master (
    output req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    output req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    input  out_resp1, out_resp2, out_resp3, out_resp4,
    input  out_data1, out_data2, out_data3, out_data4
  );

  modport slave (
    input  req1_cmd_in, req2_cmd_in, req3_cmd_in, req4_cmd_in,
    input  req1_data_in, req2_data_in, req3_data_in, req4_data_in,
    output out_resp1, out_resp2, out_resp3, out_resp4,
    output out_data1, out_data2, out_data3, out_data4
  );

endinterface

// File: rtl/calc1_channel.sv
// One calculator channel: IDLE captures cmd/op1, OP2 captures op2, EXEC registers the result
// for a single cycle.
module calc1_channel
  import calc1_pkg::*;
(
  input  logic              c_clk,
  input  logic              reset,
  input  logic [CMD_W-1:0]  cmd_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [RESP_W-1:0] resp_o,
  output logic [DATA_W-1:0] data_o
);

  state_e             state_q;
  logic [CMD_W-1:0]   cmd_q;
  logic [DATA_W-1:0]  op1_q;
  logic [DATA_W-1:0]  op2_q;
  logic [RESP_W-1:0]  resp_q;
  logic [DATA_W-1:0]  data_q;

  logic [RESP_W-1:0]  resp_d;
  logic [DATA_W-1:0]  data_d;
  logic [DATA_W:0]    sum_c;

  // ALU on the captured operands; errors and invalid commands return zero data
  always_comb begin
    resp_d = RESP_INVALID;
    data_d = '0;
    sum_c  = {1'b0, op1_q} + {1'b0, op2_q};
    case (cmd_q)
      CMD_ADD: begin
        if (sum_c[DATA_W]) begin
          resp_d = RESP_ERR;
        end else begin
          resp_d = RESP_OK;
          data_d = sum_c[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (op2_q > op1_q) begin
          resp_d = RESP_ERR;
        end else begin
          resp_d = RESP_OK;
          data_d = op1_q - op2_q;
        end
      end
      CMD_SHL: begin
        resp_d = RESP_OK;
        data_d = op1_q << op2_q[SHAMT_W-1:0];
      end
      CMD_SHR: begin
        resp_d = RESP_OK;
        data_d = op1_q >> op2_q[SHAMT_W-1:0];
      end
      default: begin
        resp_d = RESP_INVALID;
        data_d = '0;
      end
    endcase
  end

  // Outputs fall back to zero on every edge that is not leaving EXEC
  always_ff @(posedge c_clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NOP;
      op1_q   <= '0;
      op2_q   <= '0;
      resp_q  <= RESP_NONE;
      data_q  <= '0;
    end else begin
      resp_q <= RESP_NONE;
      data_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_i != CMD_NOP) begin
            cmd_q   <= cmd_i;
            op1_q   <= data_i;
            state_q <= ST_OP2;
          end
        end
        ST_OP2: begin
          op2_q   <= data_i;
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          resp_q  <= resp_d;
          data_q  <= data_d;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_o = resp_q;
  assign data_o = data_q;

endmodule

// File: rtl/calc1.sv
// Four-channel 32-bit calculator: four independent calc1_channel instances, no shared state.
module calc1 (
  input  logic  c_clk,
  input  logic  reset,
  calc1_if.slave bus
);

  calc1_channel u_ch1 (
    .c_clk  (c_clk),
    .reset  (reset),
    .cmd_i  (bus.req1_cmd_in),
    .data_i (bus.req1_data_in),
    .resp_o (bus.out_resp1),
    .data_o (bus.out_data1)
  );

  calc1_channel u_ch2 (
    .c_clk  (c_clk),
    .reset  (reset),
    .cmd_i  (bus.req2_cmd_in),
    .data_i (bus.req2_data_in),
    .resp_o (bus.out_resp2),
    .data_o (bus.out_data2)
  );

  calc1_channel u_ch3 (
    .c_clk  (c_clk),
    .reset  (reset),
    .cmd_i  (bus.req3_cmd_in),
    .data_i (bus.req3_data_in),
    .resp_o (bus.out_resp3),
    .data_o (bus.out_data3)
  );

  calc1_channel u_ch4 (
    .c_clk  (c_clk),
    .reset  (reset),
    .cmd_i  (bus.req4_cmd_in),
    .data_i (bus.req4_data_in),
    .resp_o (bus.out_resp4),
    .data_o (bus.out_data4)
  );

endmodule

// File: tb/tb_calc1.sv
// Self-checking bench for calc1: every output of every channel is compared each cycle
// against a timeline of expected responses filled from an arithmetic reference model.
module tb_calc1;

  localparam int unsigned MAXC = 3000;

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
  } txn_t;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cmd_a [4];
  logic [31:0] dat_a [4];
  logic [1:0]  resp_w [4];
  logic [31:0] data_w [4];

  logic [33:0] exp_v [4][MAXC];
  txn_t        q [4][$];
  int unsigned cyc    = 0;
  int unsigned n_vec  = 0;
  int unsigned n_err  = 0;

  calc1_if bus ();

  calc1 dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 c_clk = ~c_clk;

  assign bus.req1_cmd_in  = cmd_a[0];
  assign bus.req2_cmd_in  = cmd_a[1];
  assign bus.req3_cmd_in  = cmd_a[2];
  assign bus.req4_cmd_in  = cmd_a[3];
  assign bus.req1_data_in = dat_a[0];
  assign bus.req2_data_in = dat_a[1];
  assign bus.req3_data_in = dat_a[2];
  assign bus.req4_data_in = dat_a[3];
  assign resp_w[0] = bus.out_resp1;
  assign resp_w[1] = bus.out_resp2;
  assign resp_w[2] = bus.out_resp3;
  assign resp_w[3] = bus.out_resp4;
  assign data_w[0] = bus.out_data1;
  assign data_w[1] = bus.out_data2;
  assign data_w[2] = bus.out_data3;
  assign data_w[3] = bus.out_data4;

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got resp=%0d data=%h, expected resp=%0d data=%h",
               tag, got[33:32], got[31:0], exp[33:32], exp[31:0]);
    end
  endtask

  // Reference: {resp, data} from the arithmetic rules, using 64-bit math for overflow
  function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned s;
    s = longint'(a) + longint'(b);
    case (c)
      4'd1: return (s > 64'hFFFF_FFFF) ? {2'd2, 32'd0} : {2'd1, 32'(s)};
      4'd2: return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
      4'd5: return {2'd1, a << (b % 32)};
      4'd6: return {2'd1, a >> (b % 32)};
      default: return {2'd3, 32'd0};
    endcase
  endfunction

  task automatic set_exp(input int ch, input int unsigned idx, input logic [33:0] v);
    if (idx < MAXC) exp_v[ch][idx] = v;
  endtask

  // Advance one edge, then compare every channel at the following falling edge
  task automatic step();
    @(posedge c_clk);
    cyc++;
    @(negedge c_clk);
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got cycle=%0d, expected below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    for (int ch = 0; ch < 4; ch++)
      check($sformatf("ch%0d@%0d", ch + 1, cyc), {resp_w[ch], data_w[ch]}, exp_v[ch][cyc]);
  endtask

  // Drain the per-channel queues; OP2/EXEC cycles carry random cmd values that must be ignored
  task automatic run(input int unsigned prob);
    int          ph [4];
    logic [31:0] b2 [4];
    int unsigned guard;
    bit          busy;
    txn_t        t;
    guard = 0;
    for (int ch = 0; ch < 4; ch++) begin
      ph[ch] = 0;
      b2[ch] = '0;
    end
    busy = 1'b1;
    while (busy && guard < 600) begin
      for (int ch = 0; ch < 4; ch++) begin
        case (ph[ch])
          0: begin
            if (q[ch].size() != 0 && $urandom_range(99) < prob) begin
              t = q[ch].pop_front();
              cmd_a[ch] = t.c;
              dat_a[ch] = t.a;
              b2[ch]    = t.b;
              set_exp(ch, cyc + 3, model(t.c, t.a, t.b));
              ph[ch] = 1;
            end else begin
              cmd_a[ch] = 4'd0;
              dat_a[ch] = 32'($urandom);
            end
          end
          1: begin
            cmd_a[ch] = 4'($urandom);
            dat_a[ch] = b2[ch];
            ph[ch]    = 2;
          end
          default: begin
            cmd_a[ch] = 4'($urandom);
            dat_a[ch] = 32'($urandom);
            ph[ch]    = 0;
          end
        endcase
      end
      step();
      guard++;
      busy = 1'b0;
      for (int ch = 0; ch < 4; ch++)
        if (q[ch].size() != 0 || ph[ch] != 0) busy = 1'b1;
    end
    if (guard >= 600) check("run_timeout", 34'd1, 34'd0);
    for (int ch = 0; ch < 4; ch++) cmd_a[ch] = 4'd0;
    step();
    step();
  endtask

  task automatic push_all(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    txn_t t;
    t.c = c;
    t.a = a;
    t.b = b;
    for (int ch = 0; ch < 4; ch++) q[ch].push_back(t);
  endtask

  initial begin
    txn_t t;
    int   ch;
    for (int i = 0; i < 4; i++) begin
      cmd_a[i] = 4'd0;
      dat_a[i] = '0;
      for (int j = 0; j < int'(MAXC); j++) exp_v[i][j] = '0;
    end

    // Reset state, with a command present that reset must override
    reset = 1'b0;
    for (int i = 0; i < 4; i++) cmd_a[i] = 4'd1;
    step();
    step();
    for (int i = 0; i < 4; i++) cmd_a[i] = 4'd0;
    reset = 1'b1;
    step();

    // No-op: nothing for 10 cycles
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 4; i++) dat_a[i] = (k % 2 == 0) ? 32'h64 : 32'h27;
      step();
    end

    // Response codes, basic ops and boundaries on every channel, back to back
    push_all(4'd1, 32'h64, 32'h27);
    push_all(4'd1, 32'hFFFF_FFFF, 32'h1);
    push_all(4'd2, 32'h22, 32'h23);
    push_all(4'h9, 32'h1234, 32'h5678);
    push_all(4'd3, 32'h1, 32'h1);
    push_all(4'hF, 32'h1, 32'h1);
    push_all(4'd1, 32'd5, 32'd1);
    push_all(4'd2, 32'd5, 32'd2);
    push_all(4'd5, 32'd3, 32'd2);
    push_all(4'd6, 32'hC, 32'd2);
    push_all(4'd1, 32'hFFFF_FFFE, 32'd1);
    push_all(4'd2, 32'd7, 32'd7);
    push_all(4'd5, 32'd1, 32'd31);
    push_all(4'd5, 32'd1, 32'h21);
    push_all(4'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run(100);

    // Isolation: 20 random transactions per channel, overlapping with random gaps
    for (int n = 0; n < 80; n++) begin
      ch = n % 4;
      case ($urandom_range(3))
        0: t.c = 4'd1;
        1: t.c = 4'd2;
        2: t.c = 4'd5;
        default: t.c = 4'd6;
      endcase
      t.a = ($urandom_range(1) == 0) ? 32'($urandom) : 32'($urandom_range(1000));
      if (t.c == 4'd5 || t.c == 4'd6) t.b = 32'($urandom_range(10));
      else t.b = ($urandom_range(1) == 0) ? 32'($urandom) : 32'($urandom_range(1000));
      q[ch].push_back(t);
    end
    run(55);

    // Reset while in OP2: the transaction vanishes, outputs stay zero
    for (int i = 0; i < 4; i++) begin
      cmd_a[i] = 4'd1;
      dat_a[i] = 32'd10;
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_a[i] = 4'd0;
      dat_a[i] = 32'd20;
    end
    step();
    for (int i = 0; i < 4; i++) cmd_a[i] = 4'd2;
    step();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) cmd_a[i] = 4'd0;
    step();
    step();
    step();

    // First command after reset completes normally
    push_all(4'd1, 32'd40, 32'd2);
    push_all(4'd2, 32'd9, 32'd4);
    run(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/calc1.md
# calc1

Four-channel 32-bit integer calculator: add, subtract, shift-left and shift-right. Each of four independent request ports accepts a command plus two operands over two consecutive cycles and returns a response code and 32-bit result on its own output port. The block is a standalone leaf sitting behind four requesters, with no shared arbitration between channels.

## Interface
- No parameters; channel count (4) and data width (32) are fixed.
- c_clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of c_clk.
- reqN_cmd_in  in  4  (N=1..4) command, valid in the operand-1 cycle only.
- reqN_data_in  in  32  (N=1..4) operand 1 in the command cycle, operand 2 in the following cycle.
- out_respN  out  2  (N=1..4) response code: 0 none, 1 success, 2 overflow/underflow, 3 invalid command.
- out_dataN  out  32  (N=1..4) result; valid only while out_respN==1.

## Operation
- Commands:
  - 0: no-op.
  - 1: op1+op2.
  - 2: op1−op2.
  - 5: op1<<op2[4:0].
  - 6: op1>>op2[4:0] (logical).
  - 3, 4 and 7–15: invalid.
- Per-channel FSM:
  - IDLE: a nonzero cmd captures cmd and op1, then goes to OP2; cmd 0 stays in IDLE.
  - OP2: captures data_in as op2 unconditionally, ignores cmd_in, then goes to EXEC.
  - EXEC: registers the response onto the outputs, then returns to IDLE.
- Cmd inputs are ignored outside IDLE.
- Add: if the 33-bit sum exceeds 32'hFFFFFFFF, resp=2, data=0. Otherwise resp=1, data=sum[31:0].
- Subtract: if op2>op1 (unsigned), resp=2, data=0. Otherwise resp=1, data=op1−op2. op2==op1 gives resp=1, data=0.
- Shifts: always resp=1. op2[31:5] is ignored. Bits shifted out are lost, with no overflow flag; zero fill.
- Invalid cmd: still consumes the op2 cycle; resp=3, data=0.
- No-op: produces no response.
- Channels are fully independent. No state is shared, and a result depends only on that transaction's cmd/op1/op2. Prior transactions on any channel do not affect it.

## Timing
- Edge E0 (IDLE, cmd≠0) captures cmd/op1. E1 captures op2. E2 loads out_respN/out_dataN.
- Response visible for exactly one cycle (E2→E3); at E3 out_respN=0 and out_dataN=0.
- Latency: 2 edges from the command edge. The next command is accepted at E3 at the earliest, so peak throughput is one transaction per 3 cycles per channel.
- When no response is being presented, out_respN=0 and out_dataN=0.
- Simultaneous commands on all four channels complete in parallel with identical latency.
- Reset (reset==0 at an edge):
  - all FSMs go to IDLE and all out_resp/out_data go to 0 at that edge;
  - any transaction in flight is discarded with no response;
  - reset dominates any command present in the same cycle;
  - reset must be held ≥1 cycle.

## Structure
- Package calc1_pkg holds:
  - cmd constants (CMD_NOP=0, CMD_ADD=1, CMD_SUB=2, CMD_SHL=5, CMD_SHR=6);
  - resp constants (RESP_NONE=0, RESP_OK=1, RESP_ERR=2, RESP_INVALID=3);
  - the FSM state enum.
- Sub-module calc1_channel (FSM, operand registers, ALU, output registers) is instantiated four times.
- The top level is wiring only.

## Test plan
- Response codes, each channel:
  - cmd0 (0x64, 0x27) → resp 0 for 10 cycles;
  - cmd1 (0x64, 0x27) → resp 1, data 0x8B;
  - cmd1 (0xFFFFFFFF, 0x1) → resp 2;
  - cmd2 (0x22, 0x23) → resp 2;
  - cmd 4'h9 → resp 3, data 0.
- Basic operations, each channel:
  - add 5+1 → 6;
  - sub 5−2 → 3;
  - shl 3<<2 → 0xC;
  - shr 0xC>>2 → 3.
  - All have resp 1 exactly 2 edges after the command edge and return to 0 one cycle later.
- Boundaries:
  - add 0xFFFFFFFE+1 → 0xFFFFFFFF resp 1;
  - sub 7−7 → 0 resp 1;
  - shl 1<<31 → 0x80000000;
  - shl 1 by 0x21 → 2 (op2[4:0]=1).
- Isolation: 80 random add/sub/shift transactions (shift amounts 0–10), 20 per channel in shuffled order and concurrently overlapping. Every result matches the reference model, with no cross-channel effect.
- Busy/reset:
  - a cmd on the OP2 or EXEC cycle is ignored;
  - reset asserted in OP2 → no response, outputs 0;
  - the next command after reset completes normally.
